// File: rtl/oam_dma_arb.sv
// oam_dma_arb
//   Bus arbiter for a sprite-memory DMA engine. A CPU write of the page number to
//   DMA_REG_ADDR stalls the CPU. The engine then copies the 256 bytes of that page
//   ({pg,8'h00}..{pg,8'hFF}) to OAM_DATA_ADDR as READ/WRITE pairs. A HALT cycle
//   comes first, and an optional ALIGN cycle follows HALT.
//
//   Build option: define OAM_DMA_ALIGN_EN to add the ALIGN cycle whenever HALT falls
//   on an odd bus cycle (stall 513/514). Undefined: no ALIGN, fixed 513-cycle stall.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cpu_addr   CPU bus address
//   cpu_wdata  CPU write data
//   cpu_we     CPU write strobe
//   cpu_rdy    CPU ready (low = CPU stalled)
//   cpu_rdata  CPU read data (mirror of mem_rdata)
//   mem_addr   shared memory bus address
//   mem_wdata  shared memory bus write data
//   mem_we     shared memory bus write strobe
//   mem_rdata  memory read data, valid the cycle after the address
//   dma_busy   high from HALT through the last WRITE
module oam_dma_arb #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        dma_busy
);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] pg;
    logic       dma_trig;

    assign dma_trig  = (state == IDLE) && cpu_we && (cpu_addr == DMA_REG_ADDR);
    assign cpu_rdata = mem_rdata;

`ifdef OAM_DMA_ALIGN_EN
    // Free-running bus-cycle parity; decides whether HALT needs an ALIGN cycle.
    logic cyc_odd;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_odd <= 1'b0;
        end else begin
            cyc_odd <= ~cyc_odd;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'h00;
            pg    <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dma_trig) begin
                        pg    <= cpu_wdata;
                        cnt   <= 8'h00;
                        state <= HALT;
                    end
                end
                HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    state <= cyc_odd ? ALIGN : READ;
`else
                    state <= READ;
`endif
                end
                ALIGN: state <= READ;
                READ:  state <= WRITE;
                WRITE: begin
                    cnt   <= cnt + 8'd1;
                    state <= (cnt == 8'hFF) ? IDLE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the current state; IDLE is a combinational pass-through so
    // the CPU sees no added latency. Reset forces the idle view with no write.
    always_comb begin
        cpu_rdy   = 1'b1;
        dma_busy  = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        if (rst) begin
            mem_we = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // The trigger write is swallowed, never reaching memory.
                    if (dma_trig) mem_we = 1'b0;
                end
                HALT, ALIGN, READ: begin
                    cpu_rdy   = 1'b0;
                    dma_busy  = 1'b1;
                    mem_addr  = {pg, cnt};
                    mem_wdata = 8'h00;
                    mem_we    = 1'b0;
                end
                WRITE: begin
                    cpu_rdy   = 1'b0;
                    dma_busy  = 1'b1;
                    mem_addr  = OAM_DATA_ADDR;
                    mem_wdata = mem_rdata;
                    mem_we    = 1'b1;
                end
                default: begin
                    cpu_rdy  = 1'b1;
                    dma_busy = 1'b0;
                end
            endcase
        end
    end

endmodule
